// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the 0011 detector feed path.
package seq_det_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } ser_state_e;

    localparam int unsigned DefaultWordW = 8;

    // Bit-counter width for a word of n bits; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bundle between the upstream feeder and the serializer.
interface seq_bit_serializer_if
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W = DefaultWordW
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              hold;
    logic              w;
    logic              w_valid;
    logic              word_start;
    logic              busy;

    // Feeder side: supplies words and stall, observes the serial stream.
    modport master (
        output in_data, in_valid, hold,
        input  in_ready, w, w_valid, word_start, busy
    );

    // Serializer side.
    modport slave (
        input  in_data, in_valid, hold,
        output in_ready, w, w_valid, word_start, busy
    );
endinterface

// File: rtl/seq_word_buffer.sv
// Single-entry word buffer with full flag; a read and a write on the same edge
// hand out the old word and keep the buffer full with the new one.
module seq_word_buffer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic              full_o,
    output logic [WORD_W-1:0] rd_data_o
);
    logic              full_q, full_d;
    logic [WORD_W-1:0] data_q, data_d;

    // Next-state: write wins over read so a simultaneous pair stays full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (rd_en_i) begin
            full_d = 1'b0;
        end
        if (wr_en_i) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o    = full_q;
    assign rd_data_o = data_q;
endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 0011 detector: one word in, one bit per clock out.
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W    = DefaultWordW,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input logic                clk_i,
    input logic                rst_i,
    seq_bit_serializer_if.slave bus
);
    localparam int unsigned      CntW    = cnt_width(WORD_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(WORD_W - 1);

    ser_state_e        state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              w_q, w_d;
    logic              w_valid_q, w_valid_d;
    logic              word_start_q, word_start_d;

    logic              pb_full;
    logic [WORD_W-1:0] pb_data;
    logic              pb_wr, pb_rd;
    logic              accept;
    logic              load;
    logic [WORD_W-1:0] load_word;

    function automatic logic first_bit(input logic [WORD_W-1:0] word);
        return MSB_FIRST ? word[WORD_W-1] : word[0];
    endfunction

    assign accept = bus.in_valid && !pb_full;

    seq_word_buffer #(
        .WORD_W (WORD_W)
    ) u_pb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (pb_wr),
        .wr_data_i (bus.in_data),
        .rd_en_i   (pb_rd),
        .full_o    (pb_full),
        .rd_data_o (pb_data)
    );

    // FSM next-state: choose between shifting, loading a new word, or going idle.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        w_d          = w_q;
        w_valid_d    = w_valid_q;
        word_start_d = 1'b0;
        pb_wr        = 1'b0;
        pb_rd        = 1'b0;
        load         = 1'b0;
        load_word    = '0;

        unique case (state_q)
            StIdle: begin
                if (!bus.hold) begin
                    if (pb_full) begin
                        pb_rd     = 1'b1;
                        load      = 1'b1;
                        load_word = pb_data;
                    end else if (accept) begin
                        load      = 1'b1;
                        load_word = bus.in_data;
                    end
                end else begin
                    pb_wr = accept;
                end
            end
            StShift: begin
                if (bus.hold) begin
                    pb_wr = accept;
                end else if (cnt_q != LastCnt) begin
                    sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
                    cnt_d = cnt_q + 1'b1;
                    w_d   = first_bit(sr_d);
                    pb_wr = accept;
                end else if (pb_full) begin
                    pb_rd     = 1'b1;
                    pb_wr     = accept;
                    load      = 1'b1;
                    load_word = pb_data;
                end else if (accept) begin
                    load      = 1'b1;
                    load_word = bus.in_data;
                end else begin
                    state_d   = StIdle;
                    w_d       = IDLE_BIT;
                    w_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A load emits the first bit of the new word on the same edge.
        if (load) begin
            sr_d         = load_word;
            cnt_d        = '0;
            w_d          = first_bit(load_word);
            w_valid_d    = 1'b1;
            word_start_d = 1'b1;
            state_d      = StShift;
        end
    end

    // State, shift register and registered serial outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            sr_q         <= '0;
            cnt_q        <= '0;
            w_q          <= IDLE_BIT;
            w_valid_q    <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            w_q          <= w_d;
            w_valid_q    <= w_valid_d;
            word_start_q <= word_start_d;
        end
    end

    assign bus.w          = w_q;
    assign bus.w_valid    = w_valid_q;
    assign bus.word_start = word_start_q;
    assign bus.in_ready   = !pb_full;
    assign bus.busy       = (state_q == StShift) || pb_full;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances.
module tb_seq_bit_serializer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    bit   log_en;
    logic w_log[$];
    logic v_log[$];
    logic s_log[$];
    logic r_log[$];

    seq_bit_serializer_if #(.WORD_W(8)) bus_m ();
    seq_bit_serializer_if #(.WORD_W(8)) bus_l ();

    seq_bit_serializer #(
        .WORD_W    (8),
        .MSB_FIRST (1'b1),
        .IDLE_BIT  (1'b0)
    ) u_dut_msb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_m)
    );

    seq_bit_serializer #(
        .WORD_W    (8),
        .MSB_FIRST (1'b0),
        .IDLE_BIT  (1'b0)
    ) u_dut_lsb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the MSB-first stream once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (log_en) begin
            w_log.push_back(bus_m.w);
            v_log.push_back(bus_m.w_valid);
            s_log.push_back(bus_m.word_start);
            r_log.push_back(bus_m.in_ready);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_log();
        @(negedge clk);
        w_log.delete();
        v_log.delete();
        s_log.delete();
        r_log.delete();
        log_en = 1'b1;
    endtask

    // Present a word and return just after the edge that accepts it.
    task automatic push(input logic [7:0] d);
        bit rdy;
        int guard;
        guard = 0;
        bus_m.in_data  = d;
        bus_m.in_valid = 1'b1;
        do begin
            rdy = bus_m.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    // Compare the logged stream against n expected bits / word_start flags (MSB first).
    task automatic check_stream(input string tag, input logic [31:0] bits,
                                input logic [31:0] starts, input int n, output int first);
        int nv;
        first = -1;
        nv    = 0;
        for (int i = 0; i < v_log.size(); i++) begin
            if (v_log[i] === 1'b1) begin
                nv++;
                if (first < 0) first = i;
            end
        end
        check_eq({tag, "_nvalid"}, nv, n);
        if (first < 0 || first + n >= w_log.size()) begin
            check_eq({tag, "_found"}, 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), w_log[first+i], bits[n-1-i]);
            check_eq($sformatf("%s_v%0d", tag, i), v_log[first+i], 1'b1);
            check_eq($sformatf("%s_s%0d", tag, i), s_log[first+i], starts[n-1-i]);
        end
        check_eq({tag, "_tail_v"}, v_log[first+n], 1'b0);
        check_eq({tag, "_tail_w"}, w_log[first+n], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   f;
        int   nv;
        int   st;
        int   zc;
        int   zpos;
        logic z;
        logic b;
        logic [7:0] exp6;

        n_vec  = 0;
        n_err  = 0;
        log_en = 1'b0;
        rst    = 1'b1;
        bus_m.in_data = '0;
        bus_m.in_valid = 1'b0;
        bus_m.hold = 1'b0;
        bus_l.in_data = '0;
        bus_l.in_valid = 1'b0;
        bus_l.hold = 1'b0;

        // Reset state
        #2;
        check_eq("rst_w", bus_m.w, 1'b0);
        check_eq("rst_w_valid", bus_m.w_valid, 1'b0);
        check_eq("rst_word_start", bus_m.word_start, 1'b0);
        check_eq("rst_in_ready", bus_m.in_ready, 1'b1);
        check_eq("rst_busy", bus_m.busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single word, first bit right after the accepting edge
        start_log();
        push(8'h33);
        check_eq("t1_latency_v", bus_m.w_valid, 1'b1);
        check_eq("t1_latency_s", bus_m.word_start, 1'b1);
        bus_m.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        log_en = 1'b0;
        check_stream("t1", 32'h33, 32'h80, 8, f);
        check_eq("t1_busy", bus_m.busy, 1'b0);

        // 2: back-to-back words, no gap
        start_log();
        push(8'h0F);
        push(8'hF0);
        bus_m.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        log_en = 1'b0;
        check_stream("t2", 32'h0FF0, 32'h8080, 16, f);

        // 3: three words, in_ready low while the buffer holds word 2
        start_log();
        push(8'hA5);
        push(8'h3C);
        push(8'h96);
        bus_m.in_valid = 1'b0;
        repeat (30) @(negedge clk);
        log_en = 1'b0;
        check_stream("t3", 32'hA53C96, 32'h808080, 24, f);
        if (f >= 0 && f + 8 < r_log.size()) begin
            for (int i = 1; i < 8; i++) begin
                check_eq($sformatf("t3_ready_low%0d", i), r_log[f+i], 1'b0);
            end
            check_eq("t3_ready_back", r_log[f+8], 1'b1);
        end else begin
            check_eq("t3_ready_window", 32'd0, 32'd1);
        end

        // 4: hold for three edges while bit 4 is on w
        start_log();
        push(8'hB4);
        bus_m.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus_m.hold = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus_m.hold = 1'b0;
        repeat (15) @(negedge clk);
        log_en = 1'b0;
        check_stream("t4", 32'b101_1000_0100, 32'b100_0000_0000, 11, f);

        // 7: word accepted in idle under hold parks in the buffer
        bus_m.hold = 1'b1;
        push(8'h5A);
        bus_m.in_valid = 1'b0;
        check_eq("t7_parked_v", bus_m.w_valid, 1'b0);
        check_eq("t7_parked_busy", bus_m.busy, 1'b1);
        check_eq("t7_parked_ready", bus_m.in_ready, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("t7_still_parked_v", bus_m.w_valid, 1'b0);
        start_log();
        bus_m.hold = 1'b0;
        repeat (15) @(negedge clk);
        log_en = 1'b0;
        check_stream("t7", 32'h5A, 32'h80, 8, f);

        // 5: async reset mid-word with the buffer full
        push(8'hC3);
        push(8'h81);
        bus_m.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("t5_pre_busy", bus_m.busy, 1'b1);
        check_eq("t5_pre_ready", bus_m.in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_w", bus_m.w, 1'b0);
        check_eq("t5_rst_v", bus_m.w_valid, 1'b0);
        check_eq("t5_rst_ready", bus_m.in_ready, 1'b1);
        check_eq("t5_rst_busy", bus_m.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start_log();
        repeat (20) @(negedge clk);
        log_en = 1'b0;
        nv = 0;
        foreach (v_log[i]) if (v_log[i] !== 1'b0) nv++;
        check_eq("t5_no_stale", nv, 0);

        // 6: LSB-first 8'h33 into a 0011 Mealy reference detector
        exp6 = 8'b1100_1100;
        st   = 0;
        zc   = 0;
        zpos = -1;
        @(negedge clk);
        bus_l.in_data  = 8'h33;
        bus_l.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_l.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t6_w%0d", i), bus_l.w, exp6[7-i]);
            check_eq($sformatf("t6_v%0d", i), bus_l.w_valid, 1'b1);
            b = bus_l.w;
            z = (st == 3) && b;
            if (z) begin
                zc++;
                zpos = i;
            end
            case (st)
                0: st = b ? 0 : 1;
                1: st = b ? 0 : 2;
                2: st = b ? 3 : 2;
                default: st = b ? 0 : 1;
            endcase
            @(posedge clk);
            #1;
        end
        check_eq("t6_tail_v", bus_l.w_valid, 1'b0);
        check_eq("t6_z_count", zc, 1);
        check_eq("t6_z_pos", zpos, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
